// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory responder: byte/half/word stores with lane merge, sign/zero-extended loads.
// Optional macro DMEM_MISALIGN_TRAP_EN: flag and suppress misaligned requests instead of force-aligning them.
`ifndef XLEN
`define XLEN 32
`endif

module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [2:0]        mem_funct3,
  input  logic [`XLEN-1:0]  mem_addr,
  input  logic [`XLEN-1:0]  mem_write_data,
  output logic [`XLEN-1:0]  mem_read_data,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              wr_q;
  logic [2:0]        funct3_q;
  logic [`XLEN-1:0]  addr_q;
  logic [`XLEN-1:0]  wdata_q;
  logic [`XLEN-1:0]  rdata_q;
  logic              ready_q;
  logic              busy_q;

  logic [31:0]       mem_array [DEPTH_WORDS];

  // Size decode of the incoming request: funct3[1:0] 00 byte, 01 half, 1x word.
  logic              in_is_half_d;
  logic              in_is_word_d;
  logic [`XLEN-1:0]  in_addr_d;
  logic              in_misalign_d;

  assign in_is_half_d = (mem_funct3[1:0] == 2'b01);
  assign in_is_word_d = mem_funct3[1];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign in_misalign_d = (in_is_half_d & mem_addr[0]) | (in_is_word_d & (mem_addr[1:0] != 2'b00));
  assign in_addr_d     = mem_addr;
`else
  assign in_misalign_d = 1'b0;
  always_comb begin
    in_addr_d = mem_addr;
    if (in_is_word_d)
      in_addr_d[1:0] = 2'b00;
    else if (in_is_half_d)
      in_addr_d[0] = 1'b0;
  end
`endif

  // Latched request decode
  logic              is_byte_d;
  logic              is_half_d;
  logic              is_word_d;
  logic [AW-1:0]     idx_d;
  logic [1:0]        lane_d;
  logic              access_d;
  logic [3:0]        be_d;
  logic [31:0]       wlane_d;
  logic [31:0]       word_rd_d;
  logic [7:0]        byte_sel_d;
  logic [15:0]       half_sel_d;
  logic [31:0]       load_ext_d;

  assign is_byte_d = (funct3_q[1:0] == 2'b00);
  assign is_half_d = (funct3_q[1:0] == 2'b01);
  assign is_word_d = funct3_q[1];
  assign idx_d     = addr_q[AW+1:2];
  assign lane_d    = addr_q[1:0];
  assign access_d  = (state_q == S_BUSY) && (cnt_q == '0);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign be_d[gi] = is_word_d
                      | (is_half_d & (lane_d[1] == 1'(gi / 2)))
                      | (is_byte_d & (lane_d == 2'(gi)));
      assign wlane_d[gi*8 +: 8] = is_word_d ? wdata_q[gi*8 +: 8]
                                : is_half_d ? wdata_q[(gi % 2)*8 +: 8]
                                :             wdata_q[7:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (access_d && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b])
          mem_array[idx_d][b*8 +: 8] <= wlane_d[b*8 +: 8];
      end
    end
  end

  assign word_rd_d = mem_array[idx_d];

  always_comb begin
    byte_sel_d = word_rd_d[7:0];
    case (lane_d)
      2'd0: byte_sel_d = word_rd_d[7:0];
      2'd1: byte_sel_d = word_rd_d[15:8];
      2'd2: byte_sel_d = word_rd_d[23:16];
      default: byte_sel_d = word_rd_d[31:24];
    endcase
  end

  assign half_sel_d = lane_d[1] ? word_rd_d[31:16] : word_rd_d[15:0];

  always_comb begin
    load_ext_d = word_rd_d;
    case (funct3_q)
      3'b000: load_ext_d = {{24{byte_sel_d[7]}}, byte_sel_d};
      3'b001: load_ext_d = {{16{half_sel_d[15]}}, half_sel_d};
      3'b100: load_ext_d = {24'd0, byte_sel_d};
      3'b101: load_ext_d = {16'd0, half_sel_d};
      default: load_ext_d = word_rd_d;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign mem_misalign = misalign_q;
`else
  assign mem_misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          if (mem_en) begin
            wr_q     <= mem_wr;
            funct3_q <= mem_funct3;
            addr_q   <= in_addr_d;
            wdata_q  <= mem_write_data;
            busy_q   <= 1'b1;
            if (in_misalign_d) begin
              // Suppressed access: complete immediately with zero data.
              state_q    <= S_RESP;
              ready_q    <= 1'b1;
              rdata_q    <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
              misalign_q <= 1'b1;
`endif
            end else begin
              state_q <= S_BUSY;
              cnt_q   <= CW'(LATENCY - 1);
            end
          end
        end
        S_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            rdata_q <= wr_q ? '0 : load_ext_d;
          end
        end
        S_RESP: begin
          state_q    <= S_IDLE;
          ready_q    <= 1'b0;
          busy_q     <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
          misalign_q <= 1'b0;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read_data = rdata_q;
  assign mem_ready     = ready_q;
  assign mem_busy      = busy_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: driver pushes expected responses, a negedge monitor pops on mem_ready.
`timescale 1ns/1ps
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_wr;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_misalign;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  dmem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk),
    .rst(rst),
    .mem_en(mem_en),
    .mem_wr(mem_wr),
    .mem_funct3(mem_funct3),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .mem_ready(mem_ready),
    .mem_busy(mem_busy),
    .mem_misalign(mem_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: one response per mem_ready strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got ready with data 0x%08h, expected no response", mem_read_data);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("rsp_data", mem_read_data, e[31:0]);
          check("rsp_misalign", {31'd0, mem_misalign}, {31'd0, e[32]});
        end
      end else if (mem_misalign) begin
        checks++;
        errors++;
        $display("FAIL misalign_without_ready: got misalign=1 ready=0, expected misalign=0");
      end
    end
  end

  task automatic wait_idle(input int exp_busy);
    int n;
    n = 0;
    @(negedge clk);
    while (mem_busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, exp_busy);
  endtask

  task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    mem_en = 1'b1;
    mem_wr = wr;
    mem_funct3 = f3;
    mem_addr = addr;
    mem_write_data = wd;
    @(posedge clk);
    #1 mem_en = 1'b0;
  endtask

  task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp, input bit exp_mis);
    exp_q.push_back({exp_mis, exp});
    issue(wr, f3, addr, wd);
    wait_idle(exp_mis ? 1 : 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_en = 1'b0;
    mem_wr = 1'b0;
    mem_funct3 = 3'd0;
    mem_addr = 32'd0;
    mem_write_data = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_read_data", mem_read_data, 32'd0);
    check("reset_ready_busy_mis", {29'd0, mem_ready, mem_busy, mem_misalign}, 32'd0);
    rst = 1'b0;

    // Word store / load
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Lane merges and extension
    do_req(1'b1, 3'b010, 32'h20, 32'h00000000, 32'h0, 1'b0);
    do_req(1'b1, 3'b000, 32'h23, 32'hFFFFFF80, 32'h0, 1'b0);
    do_req(1'b1, 3'b001, 32'h20, 32'hABCD1234, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h80001234, 1'b0);
    do_req(1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, 3'b100, 32'h23, 32'h0, 32'h00000080, 1'b0);
    do_req(1'b0, 3'b001, 32'h20, 32'h0, 32'h00001234, 1'b0);
    do_req(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8000, 1'b0);
    do_req(1'b0, 3'b101, 32'h22, 32'h0, 32'h00008000, 1'b0);
    do_req(1'b0, 3'b000, 32'h20, 32'h0, 32'h00000034, 1'b0);
    do_req(1'b0, 3'b011, 32'h20, 32'h0, 32'h80001234, 1'b0);

    // Address wrap modulo 4 KiB
    do_req(1'b1, 3'b010, 32'h1004, 32'hA5A5A5A5, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h0004, 32'h0, 32'hA5A5A5A5, 1'b0);

    // Request presented during BUSY/RESP is ignored
    do_req(1'b1, 3'b010, 32'h14, 32'h0BADF00D, 32'h0, 1'b0);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clk);
    mem_en = 1'b1;
    mem_wr = 1'b1;
    mem_funct3 = 3'b010;
    mem_addr = 32'h14;
    mem_write_data = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk);
    mem_en = 1'b0;
    wait_idle(0);
    do_req(1'b0, 3'b010, 32'h14, 32'h0, 32'h0BADF00D, 1'b0);

    // Misaligned accesses
    if (TRAP) begin
      do_req(1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1);
      do_req(1'b1, 3'b001, 32'h21, 32'h0000BEEF, 32'h0, 1'b1);
      do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h80001234, 1'b0);
    end else begin
      do_req(1'b0, 3'b010, 32'h22, 32'h0, 32'h80001234, 1'b0);
      do_req(1'b1, 3'b001, 32'h21, 32'h0000BEEF, 32'h0, 1'b0);
      do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h8000BEEF, 1'b0);
    end

    // Reset mid-BUSY aborts a pending store
    do_req(1'b1, 3'b010, 32'h30, 32'h11111111, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 3'b010, 32'h30, 32'h22222222);
    @(negedge clk);
    check("busy_before_abort", {31'd0, mem_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_read_data", mem_read_data, 32'd0);
    check("abort_ready_busy_mis", {29'd0, mem_ready, mem_busy, mem_misalign}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 3'b010, 32'h30, 32'h0, 32'h11111111, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Multi-cycle data-memory responder that services load/store requests issued by the MEM pipeline stage.
- Owns a word-organised storage array and applies byte/half/word lane selection on writes and sign/zero extension on reads.
- Holds off the pipeline with mem_busy for a configurable access latency, then returns a one-cycle mem_ready strobe.
- Sits between the MEM stage and storage, in place of the single-cycle data memory.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of 2.
- LATENCY, 2, number of cycles spent in BUSY before the access occurs; must be >= 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- mem_en  in  1  request valid, sampled only in IDLE
- mem_wr  in  1  1 = store, 0 = load
- mem_funct3  in  3  size/sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
- mem_addr  in  `XLEN  byte address
- mem_write_data  in  `XLEN  store data, right-aligned
- mem_read_data  out  `XLEN  extended load data, valid while mem_ready=1
- mem_ready  out  1  one-cycle completion strobe
- mem_busy  out  1  stall to pipeline; high in BUSY and RESP
- mem_misalign  out  1  one-cycle strobe on a misaligned request

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset: state=IDLE. mem_read_data=0, mem_ready=0, mem_busy=0, mem_misalign=0. Latched request fields cleared. Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE, on an edge with mem_en=1:
  - Latch wr, funct3, addr and wdata.
  - If aligned: go to BUSY and load cnt=LATENCY-1.
  - If misaligned (half with addr[0]=1, or word with addr[1:0]!=0): no array access. Go to RESP with read data 0 and mem_misalign=1 for that RESP cycle.
- BUSY:
  - cnt!=0: decrement cnt.
  - cnt==0: perform the access at this edge and go to RESP.
- RESP: mem_ready=1 for exactly one cycle, then return to IDLE.
- Latency: a request sampled at edge k is accessed at edge k+LATENCY and reported with mem_ready high in the cycle after that edge. The FSM is back in IDLE after edge k+LATENCY+1.
- Back-to-back: mem_en seen in BUSY or RESP is ignored. The pipeline must hold the request until mem_busy is low.
- Address mapping:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo the array size.
  - Byte lane = addr[1:0].
- Stores:
  - Byte: write wdata[7:0] to lane addr[1:0].
  - Half: write wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Word: write all four lanes.
  - Other lanes are unchanged. Unsigned funct3 codes on stores are treated as their signed equivalents.
- Loads:
  - Select the addressed byte or half.
  - funct3 000/001: sign-extend to 32 bits. 100/101: zero-extend.
  - funct3 011, 110 or 111 is treated as a word access.
  - mem_read_data is registered at the access edge and held until the next completion. For stores it is 0.
- Reset mid-operation: the FSM aborts to IDLE. A store whose access edge has not yet occurred is not written.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: misaligned requests are suppressed and flagged as described in Behaviour.
- Undefined:
  - No misalignment check. mem_misalign is tied to 0.
  - Misaligned addresses are force-aligned by clearing addr[0] for half and addr[1:0] for word, then serviced normally with full latency.

Test Plan (all scenarios use LATENCY=2):
- Reset: assert rst mid-BUSY -> all outputs 0 immediately. A subsequent load from the aborted store address returns the old value.
- SW, then LW to 0x10: store 0xDEADBEEF -> each request shows mem_busy high for 3 cycles and mem_ready one cycle. The load returns 0xDEADBEEF.
- Byte/half writes: after SW 0x00000000 at 0x20, SB 0x80 at 0x23 and SH 0x1234 at 0x20 -> LW returns 0x80001234. LB at 0x23 returns 0xFFFFFF80. LBU at 0x23 returns 0x00000080. LH at 0x20 returns 0x00001234.
- Wrap: with DEPTH_WORDS=1024, SW 0xA5A5A5A5 at 0x1004 -> LW at 0x0004 returns 0xA5A5A5A5.
- Ignored request: assert mem_en with a different address during BUSY -> no extra mem_ready, and the first request completes unchanged.
- Misalign: LW at 0x22 with the macro defined -> mem_misalign and mem_ready both high one cycle after the sampling edge, data 0, memory unchanged. With the macro undefined -> the read comes from 0x20.
